mem_resp: RTL and testbench

Memory-side responder for the CPU core's bus: the other end of the core's instruction-fetch, data-read and data-write handshakes. It serializes each request onto a single 16-bit synchronous SRAM port, or onto a simple I/O port when `io_access` is set. It returns the matching one-cycle `idone`/`rdone`/`wdone` pulse. It sits between the core and the on-chip/external SRAM and peripheral fabric.

---
 rtl/mem_resp_pkg.sv | 22 ++
 rtl/mem_resp.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_resp.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types for the memory-side responder: FSM states and the latched
// request kind.
package mem_resp_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR_LO = 3'd1,
    S_WR_HI = 3'd2,
    S_RD_LO = 3'd3,
    S_RD_HI = 3'd4,
    S_WAIT  = 3'd5,
    S_IO    = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    REQ_FETCH = 2'd0,
    REQ_READ  = 2'd1,
    REQ_WRITE = 2'd2
  } req_t;

endpackage

// File: rtl/mem_resp.sv
// Memory-side responder: serializes core fetch/read/write requests onto one
// 16-bit synchronous SRAM port or a simple I/O port, one request at a time.
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int RV  = 32,
  parameter int VA  = RV,
  parameter int LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [VA-2:0]         pc,
  input  logic                  ifetch,
  output logic                  idone,
  output logic [15:0]           idata,
  input  logic [VA-RV/16-1:0]   addr,
  input  logic [1:0]            rstrobe,
  output logic                  rdone,
  output logic [RV-1:0]         rdata,
  input  logic [RV/8-1:0]       wmask,
  input  logic [RV-1:0]         wdata,
  output logic                  wdone,
  input  logic                  io_access,
  output logic [VA-2:0]         sram_addr,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [1:0]            sram_be,
  output logic [15:0]           sram_wdata,
  input  logic [15:0]           sram_rdata,
  output logic                  io_rd,
  output logic                  io_wr,
  output logic [VA-RV/16-1:0]   io_addr,
  output logic [RV/8-1:0]       io_be,
  output logic [RV-1:0]         io_wdata,
  input  logic [RV-1:0]         io_rdata,
  input  logic                  io_ready,
  output logic [2:0]            o_dbg_state
);

  localparam int AW = VA - RV/16;
  localparam int CW = $clog2(LAT + 1);

  state_t          r_state;
  state_t          w_next;
  req_t            r_type;
  logic            r_word;
  logic            r_hi;
  logic [VA-2:0]   r_pc;
  logic [AW-1:0]   r_addr;
  logic [3:0]      r_wmask;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic [15:0]     r_idata;
  logic [CW-1:0]   r_cnt;

  logic [3:0]      w_wmask4;
  logic [31:0]     w_wdata32;
  logic [31:0]     w_io_rdata32;
  logic [VA-2:0]   w_data_haddr;
  logic            w_wr_req;
  logic            w_rd_req;
  logic            w_last_wait;
  logic            w_in_io;

  assign w_wr_req    = |wmask;
  assign w_rd_req    = |rstrobe;
  assign w_last_wait = (r_cnt == CW'(1));
  assign w_in_io     = (r_state == S_IO);

  // Requests and read data are held internally at 32-bit width; the 16-bit
  // core simply never sees or drives the upper half.
  if (RV == 32) begin : g_rv32
    assign w_wmask4     = wmask;
    assign w_wdata32    = wdata;
    assign w_io_rdata32 = io_rdata;
    assign w_data_haddr = {r_addr, (r_state == S_RD_HI) || (r_state == S_WR_HI)};
    assign rdata        = r_rdata;
    assign io_be        = w_in_io ? r_wmask : '0;
    assign io_wdata     = w_in_io ? r_wdata : '0;
  end else begin : g_rv16
    assign w_wmask4     = {2'b00, wmask};
    assign w_wdata32    = {16'h0000, wdata};
    assign w_io_rdata32 = {16'h0000, io_rdata};
    assign w_data_haddr = r_addr;
    assign rdata        = r_rdata[15:0];
    assign io_be        = w_in_io ? r_wmask[1:0] : '0;
    assign io_wdata     = w_in_io ? r_wdata[15:0] : '0;
  end

  assign io_addr     = w_in_io ? r_addr : '0;
  assign idata       = r_idata;
  assign o_dbg_state = r_state;

  // Handshake: a request is a level held by the core until its done pulse;
  // done is high for the single DONE cycle, during which the still-held
  // request is ignored so it cannot be accepted twice.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_wr_req) begin
          if (io_access)          w_next = S_IO;
          else if (|w_wmask4[1:0]) w_next = S_WR_LO;
          else                     w_next = S_WR_HI;
        end else if (w_rd_req) begin
          if (io_access)                     w_next = S_IO;
          else if (RV == 16 || rstrobe[0])   w_next = S_RD_LO;
          else                               w_next = S_RD_HI;
        end else if (ifetch) begin
          w_next = S_RD_LO;
        end
      end
      S_WR_LO: w_next = (|r_wmask[3:2]) ? S_WR_HI : S_DONE;
      S_WR_HI: w_next = S_DONE;
      S_RD_LO: w_next = S_WAIT;
      S_RD_HI: w_next = S_WAIT;
      S_WAIT: begin
        if (w_last_wait) w_next = (r_word && !r_hi) ? S_RD_HI : S_DONE;
      end
      S_IO:    if (io_ready) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = 2'b00;
    sram_wdata = 16'h0000;
    sram_addr  = '0;
    io_rd      = 1'b0;
    io_wr      = 1'b0;
    idone      = 1'b0;
    rdone      = 1'b0;
    wdone      = 1'b0;
    unique case (r_state)
      S_WR_LO: begin
        sram_ce    = 1'b1;
        sram_we    = 1'b1;
        sram_be    = r_wmask[1:0];
        sram_wdata = r_wdata[15:0];
        sram_addr  = w_data_haddr;
      end
      S_WR_HI: begin
        sram_ce    = 1'b1;
        sram_we    = 1'b1;
        sram_be    = r_wmask[3:2];
        sram_wdata = r_wdata[31:16];
        sram_addr  = w_data_haddr;
      end
      S_RD_LO, S_RD_HI: begin
        sram_ce   = 1'b1;
        sram_be   = 2'b11;
        sram_addr = (r_type == REQ_FETCH) ? r_pc : w_data_haddr;
      end
      S_IO: begin
        io_rd = (r_type == REQ_READ);
        io_wr = (r_type == REQ_WRITE);
      end
      S_DONE: begin
        idone = (r_type == REQ_FETCH);
        rdone = (r_type == REQ_READ);
        wdone = (r_type == REQ_WRITE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_type  <= REQ_FETCH;
      r_word  <= 1'b0;
      r_hi    <= 1'b0;
      r_pc    <= '0;
      r_addr  <= '0;
      r_wmask <= 4'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_idata <= 16'h0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (w_wr_req || w_rd_req || ifetch) begin
            r_type  <= w_wr_req ? REQ_WRITE : (w_rd_req ? REQ_READ : REQ_FETCH);
            r_word  <= (RV == 32) && (&rstrobe) && !w_wr_req;
            r_pc    <= pc;
            r_addr  <= addr;
            r_wmask <= w_wmask4;
            r_wdata <= w_wdata32;
          end
        end
        S_RD_LO: begin
          r_hi  <= 1'b0;
          r_cnt <= CW'(LAT);
        end
        S_RD_HI: begin
          r_hi  <= 1'b1;
          r_cnt <= CW'(LAT);
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          // SRAM data is valid only on the last wait cycle of the access.
          if (w_last_wait) begin
            if (r_type == REQ_FETCH) r_idata <= sram_rdata;
            else if (!r_word)        r_rdata <= {16'h0000, sram_rdata};
            else if (r_hi)           r_rdata[31:16] <= sram_rdata;
            else                     r_rdata[15:0] <= sram_rdata;
          end
        end
        S_IO: begin
          if (io_ready && r_type == REQ_READ) r_rdata <= w_io_rdata32;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_resp.sv
// Bench for mem_resp: directed and random requests checked against a
// request-level model of SRAM contents, access order and done timing.
module tb_mem_resp;

  localparam int RV  = 32;
  localparam int VA  = 32;
  localparam int LAT = 2;
  localparam int EW  = 50;
  localparam int K_FETCH = 0;
  localparam int K_READ  = 1;
  localparam int K_WRITE = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [VA-2:0] pc;
  logic          ifetch, idone;
  logic [15:0]   idata;
  logic [VA-3:0] addr;
  logic [1:0]    rstrobe;
  logic          rdone, wdone, io_access;
  logic [31:0]   rdata, wdata;
  logic [3:0]    wmask;
  logic [VA-2:0] sram_addr;
  logic          sram_ce, sram_we;
  logic [1:0]    sram_be;
  logic [15:0]   sram_wdata, sram_rdata;
  logic          io_rd, io_wr, io_ready;
  logic [VA-3:0] io_addr;
  logic [3:0]    io_be;
  logic [31:0]   io_wdata, io_rdata;
  logic [2:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  logic [15:0]   mem     [0:255];
  logic [15:0]   ref_mem [0:255];
  logic [15:0]   rd_pipe [0:LAT-1];
  logic [15:0]   exp_idata;
  logic [31:0]   exp_rdata;

  always #5 clk = ~clk;

  mem_resp #(.RV(RV), .VA(VA), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .pc(pc), .ifetch(ifetch), .idone(idone), .idata(idata),
    .addr(addr), .rstrobe(rstrobe), .rdone(rdone), .rdata(rdata),
    .wmask(wmask), .wdata(wdata), .wdone(wdone), .io_access(io_access),
    .sram_addr(sram_addr), .sram_ce(sram_ce), .sram_we(sram_we),
    .sram_be(sram_be), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr), .io_be(io_be),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ready(io_ready),
    .o_dbg_state(dbg_state)
  );

  // Synchronous SRAM with LAT-cycle read latency
  always @(posedge clk) begin
    rd_pipe[0] <= (sram_ce && !sram_we) ? mem[sram_addr[7:0]] : 16'h0BAD;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (sram_ce && sram_we) begin
      if (sram_be[0]) mem[sram_addr[7:0]][7:0]  = sram_wdata[7:0];
      if (sram_be[1]) mem[sram_addr[7:0]][15:8] = sram_wdata[15:8];
    end
  end
  assign sram_rdata = rd_pipe[LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] acc(input logic we, input logic [1:0] be,
                                        input logic [30:0] a, input logic [15:0] d);
    return {we, be, a, (we ? d : 16'h0000)};
  endfunction

  task automatic set_mem(input int a, input logic [15:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  // Model a write of one halfword under a 2-bit byte mask
  task automatic model_write(input logic [30:0] a, input logic [1:0] be, input logic [15:0] d);
    exp_q.push_back(acc(1'b1, be, a, d));
    if (be[0]) ref_mem[a[7:0]][7:0]  = d[7:0];
    if (be[1]) ref_mem[a[7:0]][15:8] = d[15:8];
  endtask

  task automatic idle_check(input int ncyc);
    int busy = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (sram_ce || idone || rdone || wdone || io_rd || io_wr) busy++;
      @(posedge clk); #1;
    end
    check("idle_quiet", busy, 0);
  endtask

  task automatic clear_inputs();
    ifetch = 1'b0; rstrobe = 2'b00; wmask = 4'h0; io_access = 1'b0; io_ready = 1'b0;
  endtask

  task automatic run_txn(input int kind, input logic io, input logic [30:0] a_pc,
                         input logic [29:0] a_addr, input logic [1:0] strobe,
                         input logic [3:0] mask, input logic [31:0] wd,
                         input int rdy_cyc, input logic [31:0] io_val);
    int exp_done, done_at, n, n_wrong, io_cyc, io_bad;
    logic my_done;
    logic [30:0] lo_a, hi_a;
    lo_a = {a_addr, 1'b0};
    hi_a = {a_addr, 1'b1};
    exp_q.delete();
    obs_q.delete();
    exp_done = 0;
    if (io) begin
      exp_done = rdy_cyc + 1;
      if (kind == K_READ) exp_rdata = io_val;
    end else if (kind == K_FETCH) begin
      exp_q.push_back(acc(1'b0, 2'b11, a_pc, 16'h0));
      exp_idata = ref_mem[a_pc[7:0]];
    end else if (kind == K_READ) begin
      if (strobe[0]) exp_q.push_back(acc(1'b0, 2'b11, lo_a, 16'h0));
      if (strobe[1]) exp_q.push_back(acc(1'b0, 2'b11, hi_a, 16'h0));
      if (strobe == 2'b11) exp_rdata = {ref_mem[hi_a[7:0]], ref_mem[lo_a[7:0]]};
      else if (strobe[0])  exp_rdata = {16'h0, ref_mem[lo_a[7:0]]};
      else                 exp_rdata = {16'h0, ref_mem[hi_a[7:0]]};
    end else begin
      if (|mask[1:0]) model_write(lo_a, mask[1:0], wd[15:0]);
      if (|mask[3:2]) model_write(hi_a, mask[3:2], wd[31:16]);
    end
    if (!io) exp_done = 1 + exp_q.size() * ((kind == K_WRITE) ? 1 : 1 + LAT);

    @(posedge clk); #1;
    pc = a_pc; addr = a_addr; wdata = wd; io_access = io;
    ifetch  = (kind == K_FETCH);
    rstrobe = (kind == K_READ) ? strobe : 2'b00;
    wmask   = (kind == K_WRITE) ? mask : 4'h0;
    done_at = -1; n = 0; n_wrong = 0; io_cyc = 0; io_bad = 0;
    while (done_at < 0 && n < 100) begin
      io_ready = io && (n == rdy_cyc);
      io_rdata = io_ready ? io_val : $urandom;
      @(negedge clk);
      if (sram_ce) obs_q.push_back(acc(sram_we, sram_be, sram_addr, sram_wdata));
      if (io_rd || io_wr) begin
        io_cyc++;
        if (io_rd != (kind == K_READ) || io_wr != (kind == K_WRITE) || io_addr !== a_addr ||
            io_be !== ((kind == K_WRITE) ? mask : 4'h0) || (kind == K_WRITE && io_wdata !== wd))
          io_bad++;
      end
      my_done = (kind == K_FETCH) ? idone : ((kind == K_READ) ? rdone : wdone);
      if (my_done) done_at = n;
      n_wrong += int'(idone) + int'(rdone) + int'(wdone) - int'(my_done);
      @(posedge clk); #1;
      n++;
    end
    clear_inputs();

    check("done_cycle", done_at, exp_done);
    check("wrong_done", n_wrong, 0);
    check("sram_count", obs_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < obs_q.size()) check("sram_access", obs_q[i], exp_q[i]);
    if (io) begin
      check("io_cycles", io_cyc, rdy_cyc);
      check("io_fields", io_bad, 0);
    end
    check("idata", idata, exp_idata);
    check("rdata", rdata, exp_rdata);
    idle_check(3);
  endtask

  // Write and fetch raised together: write first, fetch when it is next seen in IDLE
  task automatic prio_test(input logic [30:0] a_pc, input logic [29:0] a_addr,
                           input logic [3:0] mask, input logic [31:0] wd);
    int n, wdone_at, idone_at, n_wd, n_id, n_rd, exp_w, exp_i;
    exp_q.delete();
    obs_q.delete();
    if (|mask[1:0]) model_write({a_addr, 1'b0}, mask[1:0], wd[15:0]);
    if (|mask[3:2]) model_write({a_addr, 1'b1}, mask[3:2], wd[31:16]);
    exp_w = 1 + exp_q.size();
    exp_i = exp_w + 1 + 2 + LAT;
    exp_q.push_back(acc(1'b0, 2'b11, a_pc, 16'h0));
    exp_idata = ref_mem[a_pc[7:0]];

    @(posedge clk); #1;
    pc = a_pc; ifetch = 1'b1; addr = a_addr; wmask = mask; wdata = wd;
    n = 0; wdone_at = -1; idone_at = -1; n_wd = 0; n_id = 0; n_rd = 0;
    while (idone_at < 0 && n < 100) begin
      @(negedge clk);
      if (sram_ce) obs_q.push_back(acc(sram_we, sram_be, sram_addr, sram_wdata));
      if (wdone) begin wdone_at = n; n_wd++; end
      if (idone) begin idone_at = n; n_id++; end
      if (rdone) n_rd++;
      @(posedge clk); #1;
      n++;
      if (wdone_at == n - 1) wmask = 4'h0;
    end
    clear_inputs();

    check("prio_wdone_cycle", wdone_at, exp_w);
    check("prio_idone_cycle", idone_at, exp_i);
    check("prio_done_counts", {n_wd[7:0], n_id[7:0], n_rd[7:0]}, {8'd1, 8'd1, 8'd0});
    check("prio_sram_count", obs_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < obs_q.size()) check("prio_sram_access", obs_q[i], exp_q[i]);
    check("prio_idata", idata, exp_idata);
    idle_check(3);
  endtask

  // Reset lands in cycle 2 of a word read
  task automatic reset_test(input logic [29:0] a_addr);
    int n_rd = 0;
    int n_ce = 0;
    @(posedge clk); #1;
    addr = a_addr; rstrobe = 2'b11;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (rdone) n_rd++;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    check("rst_sram", {sram_addr, sram_ce, sram_we, sram_be, sram_wdata}, 64'h0);
    check("rst_done_data", {idone, rdone, wdone, idata, rdata}, 64'h0);
    check("rst_io", {io_rd, io_wr, io_be, io_addr}, 64'h0);
    check("rst_io_wdata", io_wdata, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_inputs();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rdone) n_rd++;
      if (sram_ce) n_ce++;
      @(posedge clk); #1;
    end
    check("rst_no_rdone", n_rd, 0);
    check("rst_no_access", n_ce, 0);
    exp_rdata = 32'h0;
    exp_idata = 16'h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pc = '0; addr = '0; wdata = 32'h0; io_rdata = 32'h0;
    clear_inputs();
    for (int i = 0; i < 256; i++) set_mem(i, 16'($urandom));
    exp_idata = 16'h0;
    exp_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {sram_ce, sram_we, idone, rdone, wdone, io_rd, io_wr, idata, rdata}, 64'h0);
    check("reset_sram_addr", sram_addr, 64'h0);
    reset = 1'b0;

    set_mem(8, 16'hA5C3);
    run_txn(K_FETCH, 1'b0, 31'd8, 30'd0, 2'b00, 4'h0, 32'h0, 0, 32'h0);
    set_mem(8, 16'h1111);
    set_mem(9, 16'h2222);
    run_txn(K_READ,  1'b0, 31'd0, 30'd4, 2'b11, 4'h0, 32'h0, 0, 32'h0);
    run_txn(K_WRITE, 1'b0, 31'd0, 30'd4, 2'b00, 4'b0100, 32'h77777777, 0, 32'h0);
    run_txn(K_WRITE, 1'b0, 31'd0, 30'd4, 2'b00, 4'b1111, 32'h12345678, 0, 32'h0);
    run_txn(K_READ,  1'b0, 31'd0, 30'd4, 2'b10, 4'h0, 32'h0, 0, 32'h0);
    run_txn(K_READ,  1'b0, 31'd0, 30'd4, 2'b01, 4'h0, 32'h0, 0, 32'h0);
    run_txn(K_READ,  1'b1, 31'd0, 30'd4, 2'b11, 4'h0, 32'h0, 4, 32'hDEADBEEF);
    run_txn(K_WRITE, 1'b1, 31'd0, 30'd9, 2'b00, 4'b1010, 32'hCAFEF00D, 2, 32'h0);
    prio_test(31'd10, 30'd5, 4'b0011, 32'h0000ABCD);
    prio_test(31'd21, 30'd10, 4'b1111, 32'h5A5A3C3C);

    for (int t = 0; t < 40; t++) begin
      int kind;
      logic io;
      kind = $urandom_range(0, 2);
      io   = (kind != K_FETCH) && ($urandom_range(0, 3) == 0);
      run_txn(kind, io, 31'($urandom_range(0, 255)), 30'($urandom_range(0, 127)),
              2'($urandom_range(1, 3)), 4'($urandom_range(1, 15)), $urandom,
              $urandom_range(1, 5), $urandom);
    end

    reset_test(30'd7);
    run_txn(K_FETCH, 1'b0, 31'd14, 30'd0, 2'b00, 4'h0, 32'h0, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
